// File: rtl/alu_operand_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_issue
// Brief    : Decode/operand-issue stage ahead of the 16-bit saturating ALU.
//            Owns an 8x16 register file, issues registered operands, writes
//            the ALU result back. Define ISSUE_FWD_EN for zero-bubble forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_issue #(
    parameter int N  = 16,
    parameter int C  = 6,
    parameter int S  = 5,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    output logic [C-1:0]  alu_opcode,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [S-1:0]  alu_shift,
    input  logic [N-1:0]  alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic [RA-1:0] res_rd,
    output logic [7:0]    drop_cnt
);

    localparam int c_NREGS = 2 ** RA;

    logic [C-1:0]  w_op;
    logic [S-1:0]  w_shift;
    logic [RA-1:0] w_rd, w_ra, w_rb;
    logic [11:0]   w_imm12;
    logic [N-1:0]  w_sext;
    logic          w_legal, w_imm_op;
    logic          w_fwd_a, w_fwd_b, w_hazard;
    logic          w_in_ready, w_accept, w_res_hs;
    logic [N-1:0]  w_opnd_a, w_opnd_b;

    logic [N-1:0]  r_rf [c_NREGS];
    logic          r_issue_valid;
    logic [C-1:0]  r_opcode;
    logic [N-1:0]  r_a, r_b;
    logic [S-1:0]  r_shift;
    logic [RA-1:0] r_res_rd;
    logic [7:0]    r_drop;

    assign w_op    = in_instr[31:26];
    assign w_shift = in_instr[25:21];
    assign w_rd    = in_instr[20:18];
    assign w_ra    = in_instr[17:15];
    assign w_rb    = in_instr[14:12];
    assign w_imm12 = in_instr[11:0];
    assign w_sext  = {{(N-12){w_imm12[11]}}, w_imm12};

    always_comb begin
        w_legal  = 1'b0;
        w_imm_op = 1'b0;
        case (w_op)
            6'd1, 6'd3, 6'd5, 6'd7, 6'd9, 6'd11,
            6'd15, 6'd17, 6'd19, 6'd21, 6'd22,
            6'd24, 6'd25, 6'd26: begin
                w_legal = 1'b1;
            end
            6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12,
            6'd16, 6'd18, 6'd20: begin
                w_legal  = 1'b1;
                w_imm_op = 1'b1;
            end
            default: begin
                w_legal  = 1'b0;
                w_imm_op = 1'b0;
            end
        endcase
    end

    // Dependency on the in-flight result; ra only counts for register-register ops
    assign w_fwd_a = r_issue_valid && !w_imm_op && (w_ra == r_res_rd);
    assign w_fwd_b = r_issue_valid && (w_rb == r_res_rd);

`ifdef ISSUE_FWD_EN
    assign w_hazard = 1'b0;
    assign w_opnd_a = w_imm_op ? w_sext : (w_fwd_a ? alu_y : r_rf[w_ra]);
    assign w_opnd_b = w_fwd_b ? alu_y : r_rf[w_rb];
`else
    assign w_hazard = w_fwd_a || w_fwd_b;
    assign w_opnd_a = w_imm_op ? w_sext : r_rf[w_ra];
    assign w_opnd_b = r_rf[w_rb];
`endif

    assign w_in_ready = !(r_issue_valid && !res_ready) && !w_hazard;
    assign w_accept   = in_valid && w_in_ready;
    assign w_res_hs   = r_issue_valid && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_res_hs) begin
            r_rf[r_res_rd] <= alu_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_opcode      <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_shift       <= '0;
            r_res_rd      <= '0;
        end else if (w_accept && w_legal) begin
            r_issue_valid <= 1'b1;
            r_opcode      <= w_op;
            r_a           <= w_opnd_a;
            r_b           <= w_opnd_b;
            r_shift       <= w_shift;
            r_res_rd      <= w_rd;
        end else if (w_res_hs) begin
            r_issue_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_accept && !w_legal && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign in_ready   = w_in_ready;
    assign alu_opcode = r_opcode;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_shift  = r_shift;
    assign res_valid  = r_issue_valid;
    assign res_data   = alu_y;
    assign res_rd     = r_res_rd;
    assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_issue
// Brief    : Self-checking bench for alu_operand_issue with an architectural
//            reference model; honours ISSUE_FWD_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [4:0]  alu_shift;
    logic [15:0] alu_y;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic [2:0]  res_rd;
    logic [7:0]  drop_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    alu_operand_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shift  (alu_shift),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .drop_cnt   (drop_cnt)
    );

    function automatic logic [15:0] alu_f(logic [5:0] op, logic [15:0] a, logic [15:0] b, logic [4:0] sh);
        return a + b + {5'd0, sh, op};
    endfunction

    assign alu_y = alu_f(alu_opcode, alu_a, alu_b, alu_shift);

    function automatic bit legal(int op);
        return (op >= 1 && op <= 12) || (op >= 15 && op <= 22) || (op >= 24 && op <= 26);
    endfunction

    function automatic bit is_imm(int op);
        return (op % 2 == 0) && op >= 2 && op <= 20 && op != 14;
    endfunction

    function automatic logic [31:0] mk(int op, int sh, int rd, int ra, int rb, int imm);
        return {6'(op), 5'(sh), 3'(rd), 3'(ra), 3'(rb), 12'(imm)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Architectural model: register file plus at most one issued instruction
    logic [15:0] m_rf [8];
    logic [15:0] n_rf [8];
    bit          m_pend = 1'b0, n_pend;
    logic [5:0]  m_op = '0, n_op;
    logic [15:0] m_a = '0, m_b = '0, n_a, n_b;
    logic [4:0]  m_sh = '0, n_sh;
    logic [2:0]  m_rd = '0, n_rd;
    int          m_drop = 0, n_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_rf[i] <= '0;
            m_pend <= 1'b0; m_op <= '0; m_a <= '0; m_b <= '0;
            m_sh <= '0; m_rd <= '0; m_drop <= 0;
        end else begin
            m_rf <= n_rf; m_pend <= n_pend; m_op <= n_op; m_a <= n_a;
            m_b <= n_b; m_sh <= n_sh; m_rd <= n_rd; m_drop <= n_drop;
        end
    end

    always @(negedge clk) begin
        logic [15:0] y;
        int op, ra, rb;
        bit dep, er, acc;
        y  = alu_f(m_op, m_a, m_b, m_sh);
        op = int'(in_instr[31:26]);
        ra = int'(in_instr[17:15]);
        rb = int'(in_instr[14:12]);
        dep = m_pend && ((!is_imm(op) && ra == int'(m_rd)) || rb == int'(m_rd));
        er  = !(m_pend && !res_ready);
`ifndef ISSUE_FWD_EN
        if (dep) er = 1'b0;
`endif
        chk("in_ready",   in_ready,   er);
        chk("res_valid",  res_valid,  m_pend);
        chk("alu_opcode", alu_opcode, m_op);
        chk("alu_a",      alu_a,      m_a);
        chk("alu_b",      alu_b,      m_b);
        chk("alu_shift",  alu_shift,  m_sh);
        chk("res_rd",     res_rd,     m_rd);
        chk("res_data",   res_data,   y);
        chk("drop_cnt",   drop_cnt,   m_drop);

        n_rf = m_rf; n_pend = m_pend; n_op = m_op; n_a = m_a;
        n_b = m_b; n_sh = m_sh; n_rd = m_rd; n_drop = m_drop;
        acc = in_valid && er;
        if (m_pend && res_ready) begin
            n_rf[m_rd] = y;
            n_pend = 1'b0;
        end
        if (acc && legal(op)) begin
            // A source equal to the pending destination sees that pending result
            n_pend = 1'b1;
            n_op   = in_instr[31:26];
            n_sh   = in_instr[25:21];
            n_rd   = in_instr[20:18];
            if (is_imm(op))
                n_a = {{4{in_instr[11]}}, in_instr[11:0]};
            else
                n_a = (m_pend && ra == int'(m_rd)) ? y : m_rf[ra];
            n_b = (m_pend && rb == int'(m_rd)) ? y : m_rf[rb];
        end else if (acc) begin
            n_drop = (m_drop == 255) ? 255 : m_drop + 1;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] ins, input bit rr, output int waits);
        bit acc;
        acc = 1'b0;
        waits = 0;
        in_valid = 1'b1; in_instr = ins; res_ready = rr;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waits++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int drops [5] = '{0, 13, 14, 23, 40};
        int op;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(mk(1, 2, 1, 0, 0, 0), 1'b1, w);
        #1;
        chk("add_opcode", alu_opcode, 1);
        chk("add_shift", alu_shift, 2);
        chk("add_a", alu_a, 0);
        chk("add_b", alu_b, 0);
        chk("add_res_valid", res_valid, 1);
        chk("add_res_rd", res_rd, 1);
        chk("add_res_data", res_data, 16'h0081);

        send(mk(2, 0, 2, 0, 1, 12'hFFF), 1'b1, w);
        #1;
        chk("addi_sext_a", alu_a, 16'hFFFF);
        chk("addi_b", alu_b, 16'h0081);

        send(mk(2, 0, 3, 0, 0, 5), 1'b1, w);
        in_valid = 1'b1;
        in_instr = mk(1, 0, 4, 3, 0, 0);
        #1;
`ifdef ISSUE_FWD_EN
        chk("dep_in_ready", in_ready, 1);
`else
        chk("dep_in_ready", in_ready, 0);
`endif
        send(mk(1, 0, 4, 3, 0, 0), 1'b1, w);
        #1;
        chk("dep_a", alu_a, 16'd7);
        chk("dep_b", alu_b, 16'd0);

        send(mk(1, 0, 5, 4, 4, 0), 1'b1, w);
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(3, 1, 6, 0, 0, 0);
        repeat (3) begin
            #1;
            chk("stall_in_ready", in_ready, 0);
            chk("stall_opcode", alu_opcode, 1);
            chk("stall_rd", res_rd, 5);
            chk("stall_a", alu_a, 16'd8);
            @(posedge clk);
        end
        #1;
        send(mk(3, 1, 6, 0, 0, 0), 1'b1, w);
        chk("stall_release_waits", w, 1);
        #1;
        chk("release_opcode", alu_opcode, 3);
        chk("release_shift", alu_shift, 1);
        send(mk(1, 0, 7, 5, 0, 0), 1'b1, w);
        #1;
        chk("wb_after_stall", alu_a, 16'd17);

        do_reset();
        foreach (drops[i]) send(mk(drops[i], 0, 1, 1, 1, 0), 1'b1, w);
        #1;
        chk("drop_res_valid", res_valid, 0);
        chk("drop_cnt5", drop_cnt, 5);
        repeat (300) send(mk(27 + int'($urandom % 37), 0, 2, 2, 2, 0), 1'b1, w);
        #1;
        chk("drop_sat", drop_cnt, 255);

        send(mk(1, 0, 5, 0, 0, 0), 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", res_valid, 0);
        chk("async_rst_opcode", alu_opcode, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(mk(1, 0, 6, 5, 5, 0), 1'b1, w);
        #1;
        chk("rst_no_wb_a", alu_a, 0);
        chk("rst_no_wb_b", alu_b, 0);

        repeat (2000) begin
            @(posedge clk);
            #1;
            if ($urandom % 5 == 0) begin
                op = int'($urandom % 64);
            end else begin
                do op = int'($urandom % 64); while (!legal(op));
            end
            in_valid  = ($urandom % 4) != 0;
            res_ready = ($urandom % 4) != 0;
            in_instr  = mk(op, int'($urandom % 32), int'($urandom % 8), int'($urandom % 8),
                           int'($urandom % 8), int'($urandom % 4096));
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
